// File: rtl/fifo_burst_drain_ctrl.sv
// Read-side DDR burst scheduler for afifo_16i_64o_512 with wrapping frame address.
// Optional macro DRAIN_FLUSH_EN enables short bursts that drain residual words.
module fifo_burst_drain_ctrl #(
  parameter int          DATA_W      = 64,
  parameter int          LEVEL_W     = 13,
  parameter int          BURST_LEN   = 64,
  parameter int          ADDR_W      = 28,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FRAME_BYTES = 4147200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               flush,
  output logic               fifo_rd_en,
  input  logic [DATA_W-1:0]  fifo_rd_data,
  input  logic               fifo_rd_empty,
  input  logic [LEVEL_W-1:0] fifo_rd_water_level,
  output logic               wr_req,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [7:0]         wr_len,
  input  logic               wr_ack,
  output logic [DATA_W-1:0]  wr_data,
  output logic               wr_data_valid,
  input  logic               wr_data_ready,
  output logic               burst_done,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] BASE =
    ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0] FRAME_END =
    (ADDR_W+1)'(BASE_ADDR + FRAME_BYTES);

  state_t            state_q;
  state_t            state_d;
  logic              fs_pend;
  logic [8:0]        rd_cnt;
  logic [7:0]        acc_cnt;
  logic              rd_pend;
  logic [1:0]        occ;
  logic [DATA_W-1:0] buf1;

  logic              start_full;
  logic              start_short;
  logic              rd_phase;
  logic              pop;
  logic              room;
  logic [ADDR_W:0]   burst_bytes;
  logic [ADDR_W:0]   addr_sum;
  logic [ADDR_W-1:0] addr_next;

  assign start_full =
    fifo_rd_water_level >= LEVEL_W'(BURST_LEN);

`ifdef DRAIN_FLUSH_EN
  logic flush_pend;
  logic flush_hit;

  assign flush_hit   = flush || flush_pend;
  assign start_short = flush_hit && !start_full &&
                       (fifo_rd_water_level != '0);

  // A flush seen while busy waits for the return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pend <= 1'b0;
    end else if (state_q != IDLE) begin
      if (flush) flush_pend <= 1'b1;
    end else if (!start_full) begin
      flush_pend <= 1'b0;
    end
  end
`else
  logic unused_flush;

  assign unused_flush = flush;
  assign start_short  = 1'b0;
`endif

  assign wr_req        = (state_q == REQ);
  assign busy          = (state_q != IDLE);
  assign wr_data_valid = (occ != 2'd0);
  assign pop           = wr_data_valid && wr_data_ready;

  // Reads may start in the ack cycle to reach a 2-cycle first-word latency.
  assign rd_phase = (state_q == DATA) ||
                    ((state_q == REQ) && wr_ack);
  assign room = (3'(occ) + 3'(rd_pend)) <
                (3'd2 + 3'(pop));
  assign fifo_rd_en = rd_phase && room &&
                      !fifo_rd_empty &&
                      (rd_cnt <= {1'b0, wr_len});

  assign burst_done = (state_q == DATA) && pop &&
                      (acc_cnt == wr_len);

  assign burst_bytes =
    (ADDR_W+1)'({1'b0, wr_len} + 9'd1) *
    (ADDR_W+1)'(DATA_W / 8);
  assign addr_sum  = {1'b0, wr_addr} + burst_bytes;
  assign addr_next = (addr_sum >= FRAME_END) ?
                     BASE : addr_sum[ADDR_W-1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_full || start_short) state_d = REQ;
      REQ:  if (wr_ack) state_d = DATA;
      DATA: if (burst_done) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_addr <= BASE;
      wr_len  <= '0;
      fs_pend <= 1'b0;
      rd_cnt  <= '0;
      acc_cnt <= '0;
      rd_pend <= 1'b0;
      occ     <= '0;
      wr_data <= '0;
      buf1    <= '0;
    end else begin
      state_q <= state_d;
      rd_pend <= fifo_rd_en;
      if (fifo_rd_en) rd_cnt <= rd_cnt + 9'd1;
      if (pop) acc_cnt <= acc_cnt + 8'd1;

      unique case (state_q)
        IDLE: begin
          rd_cnt  <= '0;
          acc_cnt <= '0;
          if (frame_start) wr_addr <= BASE;
          if (start_full)
            wr_len <= 8'(BURST_LEN - 1);
          else if (start_short)
            wr_len <= 8'(fifo_rd_water_level - LEVEL_W'(1));
        end
        REQ, DATA: begin
          if (frame_start) fs_pend <= 1'b1;
        end
        DONE: begin
          wr_addr <= (frame_start || fs_pend) ?
                     BASE : addr_next;
          fs_pend <= 1'b0;
        end
        default: ;
      endcase

      // Skid buffer: wr_data is the head, buf1 the second entry.
      unique case ({rd_pend, pop})
        2'b10: begin
          if (occ == 2'd0) wr_data <= fifo_rd_data;
          else             buf1    <= fifo_rd_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          if (occ == 2'd2) wr_data <= buf1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            wr_data <= buf1;
            buf1    <= fifo_rd_data;
          end else begin
            wr_data <= fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_drain_ctrl.sv
// Directed bench for fifo_burst_drain_ctrl with a FIFO model and a DDR sink.
// Frame size is shortened so the address wrap is reached in a few bursts.
module tb_fifo_burst_drain_ctrl;

  localparam int DATA_W  = 64;
  localparam int LEVEL_W = 13;
  localparam int ADDR_W  = 28;
  localparam int FRAME_B = 5120;

  logic               clk;
  logic               rst;
  logic               frame_start;
  logic               flush;
  logic               fifo_rd_en;
  logic [DATA_W-1:0]  fifo_rd_data;
  logic               fifo_rd_empty;
  logic [LEVEL_W-1:0] fifo_rd_water_level;
  logic               wr_req;
  logic [ADDR_W-1:0]  wr_addr;
  logic [7:0]         wr_len;
  logic               wr_ack;
  logic [DATA_W-1:0]  wr_data;
  logic               wr_data_valid;
  logic               wr_data_ready;
  logic               burst_done;
  logic               busy;

  fifo_burst_drain_ctrl #(
    .FRAME_BYTES(FRAME_B)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .frame_start        (frame_start),
    .flush              (flush),
    .fifo_rd_en         (fifo_rd_en),
    .fifo_rd_data       (fifo_rd_data),
    .fifo_rd_empty      (fifo_rd_empty),
    .fifo_rd_water_level(fifo_rd_water_level),
    .wr_req             (wr_req),
    .wr_addr            (wr_addr),
    .wr_len             (wr_len),
    .wr_ack             (wr_ack),
    .wr_data            (wr_data),
    .wr_data_valid      (wr_data_valid),
    .wr_data_ready      (wr_data_ready),
    .burst_done         (burst_done),
    .busy               (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] exp_q[$];
  int          wcnt = 0;
  int          ack_dly = 3;
  int          rdy_mode = 0;
  int          rdy_cnt = 0;
  int          req_age = 0;
  logic        rd_seen = 0;
  int          nreq = 0;
  int          ndone = 0;
  int          burst_words = 0;
  int          done_words = 0;
  int          rd_total = 0;
  int          acc_total = 0;
  int          max_out = 0;
  logic        prev_stall = 0;
  logic [DATA_W-1:0] prev_data = '0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [7:0]  last_len = '0;

  typedef struct {
    int                nwr;
    int                ack_dly;
    int                rdy_mode;
    bit                fs_mid;
    logic [ADDR_W-1:0] exp_addr;
    int                exp_lvl;
  } vec_t;

  vec_t vecs[5];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic upd();
    fifo_rd_water_level = LEVEL_W'(q.size());
    fifo_rd_empty = (q.size() == 0);
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic write_words(input int n);
    for (int i = 0; i < n; i++) begin
      logic [DATA_W-1:0] w;
      w = 64'hFFFF_FFFF_FFFF_FFFF - 64'(wcnt);
      wcnt++;
      q.push_back(w);
      exp_q.push_back(w);
    end
    upd();
  endtask

  task automatic wait_words(input int n);
    int k;
    k = 0;
    while (burst_words < n && k < 1000) begin
      tick();
      k++;
    end
    if (k >= 1000) begin
      checks++;
      errors++;
      $display("FAIL wait_words timeout got=%0d want=%0d",
               burst_words, n);
    end
  endtask

  task automatic wait_burst(input string nm,
                            input int d0,
                            input logic [ADDR_W-1:0] a,
                            input logic [7:0] l);
    int k;
    k = 0;
    while (ndone == d0 && k < 2000) begin
      tick();
      k++;
    end
    if (k >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got=%0d want=%0d",
               nm, ndone, d0 + 1);
      return;
    end
    chk({nm, "_addr"}, 64'(last_addr), 64'(a));
    chk({nm, "_len"}, 64'(last_len), 64'(l));
    chk({nm, "_words"}, 64'(done_words), 64'(l) + 1);
    repeat (3) tick();
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_ndone"}, 64'(ndone), 64'(d0 + 1));
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
    chk({nm, "_req"}, 64'(wr_req), 64'd0);
    chk({nm, "_addr"}, 64'(wr_addr), 64'd0);
    chk({nm, "_len"}, 64'(wr_len), 64'd0);
    chk({nm, "_data"}, wr_data, 64'd0);
    chk({nm, "_valid"}, 64'(wr_data_valid), 64'd0);
    chk({nm, "_done"}, 64'(burst_done), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Read enable is sampled after the bench has settled its inputs.
  always @(negedge clk) begin
    #2;
    rd_seen = fifo_rd_en && !rst;
  end

  // FIFO and DDR port model, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      q.delete();
      wr_ack = 1'b0;
      req_age = 0;
    end else begin
      if (rd_seen) fifo_rd_data = q.pop_front();
      if (wr_ack) begin
        wr_ack = 1'b0;
        req_age = 0;
      end else if (wr_req) begin
        req_age++;
        if (req_age >= ack_dly) wr_ack = 1'b1;
      end
    end
    rdy_cnt++;
    wr_data_ready = (rdy_mode == 0) ? 1'b1 :
                    (((rdy_cnt / 3) % 2) == 0);
    upd();
  end

  // Sink: scoreboard, stall stability and outstanding-read tracking.
  always @(negedge clk) begin
    if (rst) begin
      burst_words = 0;
      rd_total = 0;
      acc_total = 0;
      prev_stall = 1'b0;
      exp_q.delete();
    end else begin
      if (prev_stall) begin
        checks++;
        if (!wr_data_valid || wr_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold got=%0h/%0b want=%0h/1",
                   wr_data, wr_data_valid, prev_data);
        end
      end
      if (wr_req && wr_ack) begin
        last_addr = wr_addr;
        last_len = wr_len;
        nreq++;
      end
      if (fifo_rd_en) rd_total++;
      if (wr_data_valid && wr_data_ready) begin
        acc_total++;
        burst_words++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL data_extra got=%0h want=none", wr_data);
        end else begin
          logic [DATA_W-1:0] e;
          e = exp_q.pop_front();
          if (wr_data !== e) begin
            errors++;
            $display("FAIL data got=%0h want=%0h", wr_data, e);
          end
        end
      end
      if (rd_total - acc_total > max_out)
        max_out = rd_total - acc_total;
      if (burst_done) begin
        ndone++;
        done_words = burst_words;
        burst_words = 0;
      end
      prev_stall = wr_data_valid && !wr_data_ready;
      prev_data = wr_data;
    end
  end

  initial begin
    int d0;
    int n;
    bit bad;

    vecs[0] = '{64, 3, 0, 1'b0, 28'd0,    0};
    vecs[1] = '{69, 1, 1, 1'b0, 28'd512,  5};
    vecs[2] = '{59, 5, 1, 1'b0, 28'd1024, 0};
    vecs[3] = '{64, 2, 0, 1'b1, 28'd1536, 0};
    vecs[4] = '{64, 1, 0, 1'b0, 28'd0,    0};

    rst = 1'b1;
    frame_start = 1'b0;
    flush = 1'b0;
    wr_ack = 1'b0;
    wr_data_ready = 1'b1;
    fifo_rd_data = '0;
    upd();
    repeat (3) tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();

    // First-word latency: valid two cycles after the ack cycle.
    ack_dly = 3;
    rdy_mode = 0;
    d0 = ndone;
    write_words(64);
    n = 0;
    while (!(wr_req && wr_ack) && n < 50) begin
      tick();
      n++;
    end
    tick();
    chk("lat_1", 64'(wr_data_valid), 64'd0);
    tick();
    chk("lat_2", 64'(wr_data_valid), 64'd1);
    wait_burst("lat", d0, 28'd0, 8'd63);

    // Reset: restarts address at 0 through a reset pulse.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      ack_dly = vecs[i].ack_dly;
      rdy_mode = vecs[i].rdy_mode;
      d0 = ndone;
      write_words(vecs[i].nwr);
      if (vecs[i].fs_mid) begin
        wait_words(10);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
      end
      wait_burst($sformatf("vec%0d", i), d0,
                 vecs[i].exp_addr, 8'd63);
      chk($sformatf("vec%0d_lvl", i),
          64'(fifo_rd_water_level), 64'(vecs[i].exp_lvl));
    end

    rdy_mode = 0;
    ack_dly = 2;
    write_words(63);
    bad = 1'b0;
    repeat (100) begin
      tick();
      if (wr_req || fifo_rd_en) bad = 1'b1;
    end
    chk("lvl63_idle", 64'(bad), 64'd0);
    d0 = ndone;
    write_words(1);
    n = 0;
    while (!wr_req && n < 10) begin
      tick();
      n++;
    end
    chk("lvl64_req", 64'(n <= 2 && wr_req), 64'd1);
    wait_burst("lvl64", d0, 28'd512, 8'd63);

    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("fs_idle_addr", 64'(wr_addr), 64'd0);

    for (int i = 0; i < 11; i++) begin
      d0 = ndone;
      write_words(64);
      wait_burst($sformatf("wrap%0d", i), d0,
                 ADDR_W'((i % 10) * 512), 8'd63);
    end

`ifdef DRAIN_FLUSH_EN
    d0 = ndone;
    write_words(10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_burst("flush", d0, 28'd512, 8'd9);
    chk("flush_next_addr", 64'(wr_addr), 64'd592);
`else
    write_words(10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bad = 1'b0;
    repeat (50) begin
      tick();
      if (wr_req) bad = 1'b1;
    end
    chk("noflush_idle", 64'(bad), 64'd0);
    d0 = ndone;
    write_words(54);
    wait_burst("noflush", d0, 28'd512, 8'd63);
`endif

    flush = 1'b1;
    tick();
    flush = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (wr_req) bad = 1'b1;
    end
    chk("flush_empty", 64'(bad), 64'd0);

    rdy_mode = 0;
    d0 = ndone;
    write_words(64);
    wait_words(20);
    rst = 1'b1;
    tick();
    chk_reset("midrst");
    rst = 1'b0;
    repeat (5) tick();
    chk("midrst_ndone", 64'(ndone), 64'(d0));
    d0 = ndone;
    write_words(64);
    wait_burst("postrst", d0, 28'd0, 8'd63);

    chk("max_outstanding", 64'(max_out <= 2), 64'd1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
